// File: rtl/fp32_add_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fp32_add_arbiter (with internal pipelined fp32_add)
//  Brief    : Round-robin sharing of one pipelined FP32 adder between N_REQ
//             requesters, with a tag pipe routing each sum to its issuer.
//  Revision : 1.0 - initial release
// ============================================================================

module fp32_add #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        valid_out,
    output logic [31:0] c_out
);
    logic        w_swap;
    logic [31:0] w_big, w_sml;
    logic [7:0]  w_eb, w_es, w_d;
    logic [23:0] w_mb, w_ms;
    logic [49:0] w_wide;
    logic [26:0] w_aln;
    logic        w_sub;
    logic [27:0] w_sum;
    logic [26:0] w_m, w_n;
    logic [9:0]  w_e, w_sh, w_en;
    logic [4:0]  w_lz;
    logic [7:0]  w_ef;
    logic        w_rnd, w_sign, w_nan, w_inf;
    logic [30:0] w_mag;
    logic [31:0] w_res;

    logic        r_vld [LATENCY];
    logic [31:0] r_dat [LATENCY];

    // Order operands by magnitude so the aligned operand is always the smaller one.
    assign w_swap = b_in[30:0] > a_in[30:0];
    assign w_big  = w_swap ? b_in : a_in;
    assign w_sml  = w_swap ? a_in : b_in;
    assign w_eb   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    assign w_es   = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    assign w_mb   = {w_big[30:23] != 8'd0, w_big[22:0]};
    assign w_ms   = {w_sml[30:23] != 8'd0, w_sml[22:0]};
    assign w_d    = w_eb - w_es;

    // Aligned smaller mantissa carries guard, round and sticky bits.
    assign w_wide = {w_ms, 26'd0} >> w_d;
    assign w_aln  = (w_d > 8'd26) ? {26'd0, |w_ms} : {w_wide[49:24], |w_wide[23:0]};
    assign w_sub  = w_big[31] ^ w_sml[31];
    assign w_sum  = w_sub ? ({1'b0, w_mb, 3'd0} - {1'b0, w_aln})
                          : ({1'b0, w_mb, 3'd0} + {1'b0, w_aln});
    assign w_m    = w_sum[27] ? {w_sum[27:2], |w_sum[1:0]} : w_sum[26:0];
    assign w_e    = {2'd0, w_eb} + {9'd0, w_sum[27]};

    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (w_m[i]) w_lz = 5'(26 - i);
        end
    end

    // Normalisation stops at the minimum exponent, leaving a subnormal.
    assign w_sh   = ({5'd0, w_lz} < w_e) ? {5'd0, w_lz} : (w_e - 10'd1);
    assign w_n    = w_m << w_sh;
    assign w_en   = w_e - w_sh;
    assign w_ef   = w_n[26] ? w_en[7:0] : 8'd0;
    assign w_rnd  = w_n[2] & (w_n[3] | w_n[1] | w_n[0]);
    // Rounding carry ripples into the exponent field (subnormal->normal, max->inf).
    assign w_mag  = {w_ef, w_n[25:3]} + {30'd0, w_rnd};
    assign w_sign = (w_sub && (w_sum == 28'd0)) ? 1'b0 : w_big[31];
    assign w_nan  = ((&a_in[30:23]) && (|a_in[22:0])) || ((&b_in[30:23]) && (|b_in[22:0]))
                  || ((&a_in[30:23]) && (&b_in[30:23]) && w_sub);
    assign w_inf  = &w_big[30:23];

    always_comb begin
        w_res = {w_sign, w_mag};
        if (w_nan) begin
            w_res = 32'h7FC0_0000;
        end else if (w_inf || (w_en >= 10'd255)) begin
            w_res = {w_sign, 8'hFF, 23'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) r_vld[i] <= 1'b0;
        end else begin
            r_vld[0] <= valid_in;
            for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_dat[0] <= w_res;
        for (int i = 1; i < LATENCY; i++) r_dat[i] <= r_dat[i-1];
    end

    assign valid_out = r_vld[LATENCY-1];
    assign c_out     = r_dat[LATENCY-1];
endmodule

module fp32_add_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ADD_LATENCY = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [N_REQ-1:0]                 req_valid_in,
    input  logic [N_REQ*32-1:0]              req_a_in,
    input  logic [N_REQ*32-1:0]              req_b_in,
    output logic [N_REQ-1:0]                 req_ready_out,
    output logic [N_REQ-1:0]                 res_valid_out,
    output logic [31:0]                      res_out,
    output logic [$clog2(ADD_LATENCY+1)-1:0] in_flight_out,
    output logic                             error_out
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ADD_LATENCY+1);

    logic [PTR_W-1:0] r_ptr;
    logic             r_tag_vld [ADD_LATENCY];
    logic [PTR_W-1:0] r_tag_idx [ADD_LATENCY];
    logic [CNT_W-1:0] r_in_flight;
    logic             r_error;

    logic             w_found, w_accept, w_tag_out_vld, w_add_vld, w_rst;
    logic [PTR_W-1:0] w_gnt_idx;
    int               w_j;
    logic [31:0]      w_add_a, w_add_b, w_add_c;

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= N_REQ) w_j = w_j - N_REQ;
            if (!w_found && req_valid_in[w_j]) begin
                w_found   = 1'b1;
                w_gnt_idx = PTR_W'(w_j);
            end
        end
    end

    assign w_accept = w_found & rst_in;
    assign w_add_a  = req_a_in[int'(w_gnt_idx)*32 +: 32];
    assign w_add_b  = req_b_in[int'(w_gnt_idx)*32 +: 32];
    assign w_rst    = ~rst_in;

    always_comb begin
        req_ready_out = '0;
        if (w_accept) req_ready_out[w_gnt_idx] = 1'b1;
    end

    fp32_add #(
        .LATENCY   (ADD_LATENCY)
    ) u_add (
        .clk       (clk_in),
        .rst       (w_rst),
        .valid_in  (w_accept),
        .a_in      (w_add_a),
        .b_in      (w_add_b),
        .valid_out (w_add_vld),
        .c_out     (w_add_c)
    );

    assign w_tag_out_vld = r_tag_vld[ADD_LATENCY-1];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_ptr       <= '0;
            r_in_flight <= '0;
            r_error     <= 1'b0;
            for (int i = 0; i < ADD_LATENCY; i++) r_tag_vld[i] <= 1'b0;
        end else begin
            r_tag_vld[0] <= w_accept;
            for (int i = 1; i < ADD_LATENCY; i++) r_tag_vld[i] <= r_tag_vld[i-1];
            if (w_accept) begin
                r_ptr <= (w_gnt_idx == PTR_W'(N_REQ-1)) ? '0 : w_gnt_idx + PTR_W'(1);
            end
            if (w_accept && !w_tag_out_vld) begin
                r_in_flight <= r_in_flight + CNT_W'(1);
            end else if (!w_accept && w_tag_out_vld) begin
                r_in_flight <= r_in_flight - CNT_W'(1);
            end
            if (w_add_vld != w_tag_out_vld) r_error <= 1'b1;
        end
    end

    // Indices need no reset: they are only looked at alongside their valid bit.
    always_ff @(posedge clk_in) begin
        r_tag_idx[0] <= w_gnt_idx;
        for (int i = 1; i < ADD_LATENCY; i++) r_tag_idx[i] <= r_tag_idx[i-1];
    end

    always_comb begin
        res_valid_out = '0;
        if (w_tag_out_vld) res_valid_out[r_tag_idx[ADD_LATENCY-1]] = 1'b1;
    end

    assign res_out       = w_add_c;
    assign in_flight_out = r_in_flight;
    assign error_out     = r_error;
endmodule

`default_nettype wire

// File: tb/tb_fp32_add_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fp32_add_arbiter
//  Brief    : Directed, table-driven self-checking bench for fp32_add_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_add_arbiter;
    localparam int L = 4;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] sum;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid_in = '0;
    logic [127:0] req_a_in = '0;
    logic [127:0] req_b_in = '0;
    logic [3:0]   req_ready_out;
    logic [3:0]   res_valid_out;
    logic [31:0]  res_out;
    logic [2:0]   in_flight_out;
    logic         error_out;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cycle_cnt = 0;
    int           n_acc = 0;
    int           n_res = 0;
    bit           mon_en = 1'b0;
    exp_t         sbq[$];
    logic [31:0]  cur_exp [4];
    vec_t         vecs [14];

    always #5 clk = ~clk;

    fp32_add_arbiter #(
        .N_REQ         (4),
        .ADD_LATENCY   (L)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .req_valid_in  (req_valid_in),
        .req_a_in      (req_a_in),
        .req_b_in      (req_b_in),
        .req_ready_out (req_ready_out),
        .res_valid_out (res_valid_out),
        .res_out       (res_out),
        .in_flight_out (in_flight_out),
        .error_out     (error_out)
    );

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001;
        return v << i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    // Result monitor: every cycle either the oldest expected result is due, or the bus is idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].due == cycle_cnt) begin
                check("res_valid", 32'(res_valid_out), 32'(oh(sbq[0].idx)));
                check("res_out", res_out, sbq[0].sum);
                void'(sbq.pop_front());
                n_res++;
            end else begin
                check("res_idle", 32'(res_valid_out), 32'd0);
            end
        end
        cycle_cnt++;
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] s);
        req_a_in[i*32 +: 32] = a;
        req_b_in[i*32 +: 32] = b;
        cur_exp[i] = s;
    endtask

    task automatic drive_cycle(input logic [3:0] vmask, input logic [3:0] exp_rdy);
        exp_t e;
        req_valid_in = vmask;
        #1;
        check("ready", 32'(req_ready_out), 32'(exp_rdy));
        check("in_flight", 32'(in_flight_out), 32'(n_acc - n_res));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                e.due = cycle_cnt + L;
                e.idx = i;
                e.sum = cur_exp[i];
                sbq.push_back(e);
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(4'b0000, 4'b0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid_in = 4'hF;
        #1;
        check("ready_in_reset", 32'(req_ready_out), 32'd0);
        sbq.delete();
        n_acc = 0;
        n_res = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{0, 32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[1]  = '{1, 32'h3F800000, 32'hBF800000, 32'h00000000};
        vecs[2]  = '{3, 32'h40400000, 32'hBF800000, 32'h40000000};
        vecs[3]  = '{0, 32'h3FC00000, 32'h40100000, 32'h40700000};
        vecs[4]  = '{1, 32'h7F800000, 32'h3F800000, 32'h7F800000};
        vecs[5]  = '{3, 32'h00000000, 32'h80000000, 32'h00000000};
        vecs[6]  = '{0, 32'h00000001, 32'h00000001, 32'h00000002};
        vecs[7]  = '{1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
        vecs[8]  = '{3, 32'h3F800000, 32'h33800000, 32'h3F800000};
        vecs[9]  = '{0, 32'h3F800000, 32'h33C00000, 32'h3F800001};
        vecs[10] = '{1, 32'h3F800001, 32'h33800000, 32'h3F800002};
        vecs[11] = '{3, 32'hC141BE77, 32'h40E6C99B, 32'hC09CB353};
        vecs[12] = '{0, 32'h007FFFFF, 32'h00000001, 32'h00800000};
        vecs[13] = '{2, 32'h43970FFD, 32'h40C91759, 32'h439A345A};

        set_op(0, 32'h3DFFCB92, 32'h3FA45D64, 32'h3FB45A1D);
        set_op(1, 32'hC141BE77, 32'h40E6C99B, 32'hC09CB353);
        set_op(2, 32'h3DE31F8A, 32'hBDD53261, 32'h3BDED290);
        set_op(3, 32'h43970FFD, 32'h40C91759, 32'h439A345A);

        // Reset held two cycles with every requester asking.
        rst_n = 1'b0;
        req_valid_in = 4'hF;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready_out), 32'd0);
        check("rst_res_valid", 32'(res_valid_out), 32'd0);
        check("rst_in_flight", 32'(in_flight_out), 32'd0);
        check("rst_error", 32'(error_out), 32'd0);
        @(posedge clk);
        #1;
        check("rst_ready2", 32'(req_ready_out), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Contention: all four valid, grants rotate starting from requester 0.
        for (int c = 0; c < 12; c++) drive_cycle(4'hF, oh(c % 4));
        idle(L + 1);

        // Single-requester vectors, including rounding and special-value boundaries.
        for (int v = 0; v < 14; v++) begin
            set_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sum);
            drive_cycle(oh(vecs[v].idx), oh(vecs[v].idx));
            idle(L);
        end

        // Pointer now 3: wrap and skip with only requesters 1 and 3 asking.
        set_op(1, 32'hC141BE77, 32'h40E6C99B, 32'hC09CB353);
        set_op(3, 32'h43970FFD, 32'h40C91759, 32'h439A345A);
        drive_cycle(4'b1010, 4'b1000);
        drive_cycle(4'b1010, 4'b0010);
        drive_cycle(4'b1010, 4'b1000);
        idle(L + 1);

        // Reset with three operations in flight: none of them may come back.
        set_op(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
        for (int c = 0; c < 3; c++) drive_cycle(4'b0001, 4'b0001);
        do_reset();
        idle(L + 2);
        check("midrst_error", 32'(error_out), 32'd0);

        // Requester 1 valid in cycles 0, 1 and 3.
        set_op(1, 32'h3FC00000, 32'h40100000, 32'h40700000);
        drive_cycle(4'b0010, 4'b0010);
        drive_cycle(4'b0010, 4'b0010);
        drive_cycle(4'b0000, 4'b0000);
        drive_cycle(4'b0010, 4'b0010);
        idle(L + 1);

        check("final_error", 32'(error_out), 32'd0);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
